// File: rtl/fp_pkg.sv
// Shared single-precision constants, opcode encodings and sequencer state type
// for the FP issue/writeback blocks.
package fp_pkg;

  localparam int          FP_W      = 32;
  localparam logic        OP_FADD   = 1'b0;
  localparam logic        OP_FSUB   = 1'b1;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF   = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF   = 32'hFF80_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic logic [31:0] fp_negate(input logic [31:0] x);
    return {~x[31], x[30:0]};
  endfunction

endpackage

// File: rtl/fp_class.sv
// Combinational IEEE-754 single-precision operand classifier, shared by the
// add sequencer and the compare/classify units.
module fp_class
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] i_x,
  output logic            is_nan,
  output logic            is_snan,
  output logic            is_inf,
  output logic            is_zero,
  output logic            is_sub
);

  logic [7:0]  w_exp;
  logic [22:0] w_mant;
  logic        w_exp_max;
  logic        w_exp_min;
  logic        w_mant_nz;

  // NOTE: pure continuous assigns with every output always driven -- no
  // incomplete if/case paths, so no latch can be inferred here.
  assign w_exp     = i_x[30:23];
  assign w_mant    = i_x[22:0];
  assign w_exp_max = (w_exp == 8'hFF);
  assign w_exp_min = (w_exp == 8'h00);
  assign w_mant_nz = (w_mant != 23'd0);

  assign is_nan  = w_exp_max &  w_mant_nz;
  assign is_snan = is_nan    & ~w_mant[22];
  assign is_inf  = w_exp_max & ~w_mant_nz;
  assign is_zero = w_exp_min & ~w_mant_nz;
  assign is_sub  = w_exp_min &  w_mant_nz;

endmodule

// File: rtl/fadd_seq.sv
// Issue/writeback sequencer in front of the fadd unit: one op in flight,
// FSUB folded into a sign flip of b, result held with NV/OF flags and latency.
module fadd_seq
  import fp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5,
  parameter int LAT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [RD_W-1:0]  req_rd,
  input  logic             flush,
  output logic             fa_valid,
  output logic [WIDTH-1:0] fa_a,
  output logic [WIDTH-1:0] fa_b,
  input  logic             fa_valid_out,
  input  logic [WIDTH-1:0] fa_y,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_nv,
  output logic             wb_of,
  output logic [LAT_W-1:0] wb_lat,
  output logic             busy
);

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [RD_W-1:0]    r_rd;
  logic               r_discard;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               r_req_ready;
  logic               r_fa_valid;
  logic               r_busy;
  logic               r_wb_valid;
  logic [RD_W-1:0]    r_wb_rd;
  logic [WIDTH-1:0]   r_wb_data;
  logic               r_wb_nv;
  logic               r_wb_of;
  logic [LAT_W-1:0]   r_wb_lat;

  logic w_a_nan, w_a_snan, w_a_inf, w_a_zero, w_a_sub;
  logic w_b_nan, w_b_snan, w_b_inf, w_b_zero, w_b_sub;
  logic w_unused_cls;

  fp_class u_cls_a (
    .i_x     (r_a),
    .is_nan  (w_a_nan),
    .is_snan (w_a_snan),
    .is_inf  (w_a_inf),
    .is_zero (w_a_zero),
    .is_sub  (w_a_sub)
  );

  fp_class u_cls_b (
    .i_x     (r_b),
    .is_nan  (w_b_nan),
    .is_snan (w_b_snan),
    .is_inf  (w_b_inf),
    .is_zero (w_b_zero),
    .is_sub  (w_b_sub)
  );

  assign w_unused_cls = &{1'b0, w_a_zero, w_a_sub, w_b_zero, w_b_sub};

  logic             w_handshake;
  logic [WIDTH-1:0] w_b_eff;
  logic [LAT_W-1:0] w_lat_inc;
  logic             w_inf_clash;
  logic             w_nv;
  logic             w_of;
  logic             w_drop;

  assign w_handshake = req_valid & r_req_ready;
  assign w_b_eff     = (req_op == OP_FADD) ? req_b : fp_negate(req_b);
  assign w_lat_inc   = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + LAT_W'(1);

  // Flags are derived from the issued operands, which stay parked in r_a/r_b.
  assign w_inf_clash = ((r_a == POS_INF) && (r_b == NEG_INF)) ||
                       ((r_a == NEG_INF) && (r_b == POS_INF));
  assign w_nv   = (fa_y == CANON_NAN) && (w_a_snan || w_b_snan || w_inf_clash);
  assign w_of   = (fa_y[30:0] == POS_INF[30:0]) &&
                  !(w_a_nan || w_a_inf) && !(w_b_nan || w_b_inf);
  assign w_drop = r_discard | flush;

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_rd        <= '0;
      r_discard   <= 1'b0;
      r_lat_cnt   <= '0;
      r_req_ready <= 1'b1;
      r_fa_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_wb_nv     <= 1'b0;
      r_wb_of     <= 1'b0;
      r_wb_lat    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_a         <= req_a;
            r_b         <= w_b_eff;
            r_rd        <= req_rd;
            r_discard   <= 1'b0;
            r_fa_valid  <= 1'b1;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_fa_valid <= 1'b0;
          r_lat_cnt  <= '0;
          if (flush) r_discard <= 1'b1;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_lat_cnt <= w_lat_inc;
          if (fa_valid_out) begin
            if (w_drop) begin
              // fadd cannot be aborted; its late result is simply dropped.
              r_discard   <= 1'b0;
              r_req_ready <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_wb_data  <= fa_y;
              r_wb_rd    <= r_rd;
              r_wb_nv    <= w_nv;
              r_wb_of    <= w_of;
              r_wb_lat   <= w_lat_inc;
              r_wb_valid <= 1'b1;
              r_state    <= ST_HOLD;
            end
          end else if (flush) begin
            r_discard <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (flush || wb_ready) begin
            r_wb_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_fa_valid  <= 1'b0;
          r_wb_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign fa_valid  = r_fa_valid;
  assign fa_a      = r_a;
  assign fa_b      = r_b;
  assign wb_valid  = r_wb_valid;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign wb_nv     = r_wb_nv;
  assign wb_of     = r_wb_of;
  assign wb_lat    = r_wb_lat;
  assign busy      = r_busy;

  // A result pulse outside ISSUE/WAIT means the fadd handshake was violated.
  a_no_stray_result: assert property (@(posedge clk) disable iff (rst)
    fa_valid_out |-> (r_state == ST_ISSUE || r_state == ST_WAIT))
    else $error("fadd_seq: fa_valid_out while not waiting for a result");

endmodule

// File: tb/tb_fadd_seq.sv
// Self-checking bench for fadd_seq: the bench plays the fadd unit with a
// chosen latency and scoreboards expected writeback results.
module tb_fadd_seq;
  import fp_pkg::*;

  localparam int WIDTH = 32;
  localparam int RD_W  = 5;
  localparam int LAT_W = 10;
  localparam int LAT_MAX = (1 << LAT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [RD_W-1:0]  req_rd;
  logic             flush;
  logic             fa_valid;
  logic [WIDTH-1:0] fa_a;
  logic [WIDTH-1:0] fa_b;
  logic             fa_valid_out;
  logic [WIDTH-1:0] fa_y;
  logic             wb_valid;
  logic             wb_ready;
  logic [RD_W-1:0]  wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             wb_nv;
  logic             wb_of;
  logic [LAT_W-1:0] wb_lat;
  logic             busy;

  always #5 clk = ~clk;

  fadd_seq #(.WIDTH(WIDTH), .RD_W(RD_W), .LAT_W(LAT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_rd       (req_rd),
    .flush        (flush),
    .fa_valid     (fa_valid),
    .fa_a         (fa_a),
    .fa_b         (fa_b),
    .fa_valid_out (fa_valid_out),
    .fa_y         (fa_y),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_nv        (wb_nv),
    .wb_of        (wb_of),
    .wb_lat       (wb_lat),
    .busy         (busy)
  );

  typedef struct {
    logic [RD_W-1:0]  rd;
    logic [WIDTH-1:0] data;
    logic             nv;
    logic             of;
    logic [LAT_W-1:0] lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_issue = 0;

  always @(posedge clk) if (fa_valid === 1'b1) n_issue++;

  // mode 0: normal, 1: flush during WAIT, 2: flush in HOLD together with wb_ready
  task automatic do_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [RD_W-1:0] rd, input logic [31:0] y, input int lat,
                       input logic nv, input logic of, input int hold, input int mode,
                       input string name);
    exp_t        e;
    int          i0;
    logic [31:0] fb;
    logic [48:0] snap;
    fb = (op == OP_FSUB) ? {~b[31], b[30:0]} : b;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    i0 = n_issue;
    if (mode == 0) begin
      e.rd = rd; e.data = y; e.nv = nv; e.of = of;
      e.lat = (lat > LAT_MAX) ? LAT_MAX[LAT_W-1:0] : lat[LAT_W-1:0];
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 1'b0;
    checks++;
    if (fa_valid !== 1'b1 || fa_a !== a || fa_b !== fb) begin
      errors++;
      $display("FAIL %s issue: got fa_valid=%b fa_a=%h fa_b=%h want 1 %h %h",
               name, fa_valid, fa_a, fa_b, a, fb);
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      flush = (k == 0 && mode == 1);
      if (k == 0) begin
        checks++;
        if (fa_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s wait: got fa_valid=%b busy=%b req_ready=%b want 0 1 0",
                   name, fa_valid, busy, req_ready);
        end
      end
    end
    flush = 1'b0;
    fa_valid_out = 1'b1; fa_y = y;
    @(negedge clk);
    fa_valid_out = 1'b0; fa_y = $urandom;
    checks++;
    if (n_issue - i0 != 1) begin
      errors++; $display("FAIL %s fa_valid pulses: got %0d want 1", name, n_issue - i0);
    end
    if (mode == 1) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s flushed result: got wb_valid=%b req_ready=%b want 0 1",
                   name, wb_valid, req_ready);
        end
        @(negedge clk);
      end
      return;
    end
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++; $display("FAIL %s wb_valid: got %b want 1", name, wb_valid);
      if (mode == 0 && sb.size() > 0) void'(sb.pop_back());
      return;
    end
    snap = {wb_rd, wb_data, wb_nv, wb_of, wb_lat};
    for (int h = 0; h < hold; h++) begin
      wb_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (wb_valid !== 1'b1 || req_ready !== 1'b0 ||
          {wb_rd, wb_data, wb_nv, wb_of, wb_lat} !== snap) begin
        errors++;
        $display("FAIL %s hold %0d: got wb_valid=%b req_ready=%b wb=%h want 1 0 %h",
                 name, h, wb_valid, req_ready, {wb_rd, wb_data, wb_nv, wb_of, wb_lat}, snap);
      end
    end
    if (mode == 2) begin
      flush = 1'b1; wb_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; wb_ready = 1'b0;
      checks++;
      if (wb_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s hold flush: got wb_valid=%b req_ready=%b busy=%b want 0 1 0",
                 name, wb_valid, req_ready, busy);
      end
      return;
    end
    wb_ready = 1'b1;
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s scoreboard: got empty queue want one entry", name);
    end else begin
      e = sb.pop_front();
      if (wb_rd !== e.rd || wb_data !== e.data || wb_nv !== e.nv ||
          wb_of !== e.of || wb_lat !== e.lat) begin
        errors++;
        $display("FAIL %s result: got rd=%0d data=%h nv=%b of=%b lat=%0d want rd=%0d data=%h nv=%b of=%b lat=%0d",
                 name, wb_rd, wb_data, wb_nv, wb_of, wb_lat,
                 e.rd, e.data, e.nv, e.of, e.lat);
      end
    end
    @(negedge clk);
    wb_ready = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after accept: got wb_valid=%b req_ready=%b busy=%b want 0 1 0",
               name, wb_valid, req_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
    flush = 1'b0; fa_valid_out = 1'b0; fa_y = '0; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || fa_valid !== 1'b0 || wb_valid !== 1'b0 || busy !== 1'b0 ||
        wb_nv !== 1'b0 || wb_of !== 1'b0 || fa_a !== '0 || fa_b !== '0 ||
        wb_data !== '0 || wb_rd !== '0 || wb_lat !== '0) begin
      errors++;
      $display("FAIL reset: got rr=%b fv=%b wv=%b busy=%b nv=%b of=%b fa_a=%h fa_b=%h d=%h rd=%0d lat=%0d want 1 and zeros",
               req_ready, fa_valid, wb_valid, busy, wb_nv, wb_of, fa_a, fa_b, wb_data, wb_rd, wb_lat);
    end
    rst = 1'b0;
  endtask

  task automatic test_fadd();
    do_op(OP_FADD, 32'h3F800000, 32'h40000000, 5'd1, 32'h40400000, 3, 0, 0, 0, 0, "fadd_l3");
    do_op(OP_FADD, 32'h3F800000, 32'h40000000, 5'd2, 32'h40400000, 1, 0, 0, 0, 0, "fadd_l1");
    do_op(OP_FADD, 32'h3F800000, 32'h40000000, 5'd3, 32'h40400000, 7, 0, 0, 0, 0, "fadd_l7");
  endtask

  task automatic test_fsub();
    do_op(OP_FSUB, 32'h3F800000, 32'h3F800000, 5'd4, 32'h00000000, 2, 0, 0, 0, 0, "fsub_zero");
  endtask

  task automatic test_nv();
    do_op(OP_FADD, 32'h7F800000, 32'hFF800000, 5'd5, 32'h7FC00000, 2, 1, 0, 0, 0, "nv_inf_clash");
    do_op(OP_FADD, 32'h7F800001, 32'h3F800000, 5'd6, 32'h7FC00000, 2, 1, 0, 0, 0, "nv_snan");
    do_op(OP_FADD, 32'h7FC00001, 32'h3F800000, 5'd7, 32'h7FC00000, 2, 0, 0, 0, 0, "nv_qnan");
    do_op(OP_FSUB, 32'h7F800000, 32'h7F800000, 5'd8, 32'h7FC00000, 2, 1, 0, 0, 0, "nv_fsub_inf");
  endtask

  task automatic test_of();
    do_op(OP_FADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd10, 32'h7F800000, 3, 0, 1, 0, 0, "of_max");
    do_op(OP_FADD, 32'h7F800000, 32'h3F800000, 5'd11, 32'h7F800000, 3, 0, 0, 0, 0, "of_inf_in");
  endtask

  task automatic test_hold();
    do_op(OP_FADD, 32'h3F800000, 32'h40000000, 5'd12, 32'h40400000, 2, 0, 0, 5, 0, "hold5");
  endtask

  task automatic test_flush();
    do_op(OP_FADD, 32'h3F800000, 32'h3F800000, 5'd13, 32'h40000000, 4, 0, 0, 0, 1, "flush_wait");
    do_op(OP_FADD, 32'h40400000, 32'h3F800000, 5'd9, 32'h40800000, 3, 0, 0, 0, 0, "after_flush");
    do_op(OP_FADD, 32'h3F800000, 32'h3F800000, 5'd14, 32'h40000000, 2, 0, 0, 2, 2, "flush_hold");
    do_op(OP_FADD, 32'h3F800000, 32'h3F800000, 5'd15, 32'h40000000, 2, 0, 0, 0, 0, "after_hflush");
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_FADD; req_a = 32'h3F800000; req_b = 32'h3F800000; req_rd = 5'd16;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_wait pre: got busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || wb_valid !== 1'b0 || fa_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_wait %0d: got rr=%b busy=%b wv=%b fv=%b want 1 0 0 0",
                 k, req_ready, busy, wb_valid, fa_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lat_sat();
    do_op(OP_FADD, 32'h3F800000, 32'h40000000, 5'd17, 32'h40400000, 1100, 0, 0, 0, 0, "lat_sat");
  endtask

  task automatic test_back_to_back();
    do_op(OP_FADD, 32'h3F800000, 32'h3F800000, 5'd18, 32'h40000000, 1, 0, 0, 0, 0, "b2b_0");
    do_op(OP_FADD, 32'h40000000, 32'h40000000, 5'd19, 32'h40800000, 1, 0, 0, 0, 0, "b2b_1");
    do_op(OP_FSUB, 32'h40800000, 32'h3F800000, 5'd20, 32'h40400000, 2, 0, 0, 0, 0, "b2b_2");
    do_op(OP_FADD, 32'h3F000000, 32'h3F000000, 5'd31, 32'h3F800000, 1, 0, 0, 0, 0, "b2b_3");
  endtask

  initial begin
    test_reset();
    test_fadd();
    test_fsub();
    test_nv();
    test_of();
    test_hold();
    test_flush();
    test_reset_wait();
    test_lat_sat();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard drain: got %0d left want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fadd_seq.md
Name: fadd_seq

Overview:
- Issue/writeback sequencer placed directly upstream of the fadd unit, between the FP decode/register-read stage and fadd.
- Accepts one FADD.S/FSUB.S request at a time with a valid/ready handshake and applies sign inversion of b for FSUB.
- Drives fadd's single-cycle valid_input, then captures fadd's one-cycle result pulse into a held register.
- Presents the result with rd tag, fflags (NV, OF) and a latency count to writeback, also with valid/ready.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- RD_W, 5, destination register tag width.
- LAT_W, 10, width of the saturating latency counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_op  in  1  0 = FADD, 1 = FSUB
- req_a  in  WIDTH  operand a, IEEE-754 single
- req_b  in  WIDTH  operand b, IEEE-754 single
- req_rd  in  RD_W  destination tag
- flush  in  1  kill the in-flight operation
- fa_valid  out  1  to fadd valid_input
- fa_a  out  WIDTH  to fadd a
- fa_b  out  WIDTH  to fadd b
- fa_valid_out  in  1  from fadd valid_output
- fa_y  in  WIDTH  from fadd y
- wb_valid  out  1  result present
- wb_ready  in  1  writeback accepts result
- wb_rd  out  RD_W  destination tag
- wb_data  out  WIDTH  result
- wb_nv  out  1  invalid-operation flag
- wb_of  out  1  overflow flag
- wb_lat  out  LAT_W  cycles from fa_valid to fa_valid_out, saturating
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - Reset values: state = IDLE; req_ready = 1 after the reset cycle; fa_valid, wb_valid, wb_nv, wb_of, busy = 0; fa_a, fa_b, wb_data, wb_rd, wb_lat = 0; discard flag = 0.
  - Reset mid-operation returns to IDLE immediately. The parent must reset fadd in the same cycle (its rst_n = ~rst), so no stale fa_valid_out can arrive.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - req_ready = 1.
  - On handshake: latch a_q = req_a; latch b_q = req_op ? {~req_b[31], req_b[30:0]} : req_b; latch rd_q; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - fa_valid = 1 for exactly this one cycle; fa_a/fa_b = a_q/b_q, held stable in all states until the next issue.
  - Clear lat_cnt; go to WAIT.
- WAIT:
  - lat_cnt increments each cycle and saturates at all-ones.
  - On fa_valid_out: capture fa_y, since it is valid only in that cycle.
  - Compute flags from a_q/b_q at capture:
    - nv = fa_y == 32'h7FC00000 and (either operand is sNaN, i.e. exp = 255, mant != 0, mant[22] = 0; or a_q, b_q are both infinite with opposite signs).
    - of = fa_y[30:0] == 31'h7F800000 and both operands finite.
  - If discard is set, go to IDLE without asserting wb_valid; otherwise go to HOLD.
- HOLD:
  - wb_valid = 1; wb_* stays stable while wb_ready = 0.
  - On wb_ready, go to IDLE; the next request can be accepted in the following cycle.
- flush:
  - In ISSUE or WAIT: set discard. fadd cannot be aborted, so the sequencer still waits for fa_valid_out and then drops the result.
  - In HOLD: wb_valid drops next cycle, go to IDLE; flush wins over a simultaneous wb_ready.
  - In IDLE: ignored; a request in the same cycle is still accepted.
- Invariant: at most one operation is in fadd; fa_valid is never asserted unless fadd is in its input state (guaranteed by waiting for the previous fa_valid_out).
- Minimum request-to-wb_valid latency = 2 + fadd latency. Throughput is one op per (fadd latency + 3) cycles.
- fa_valid_out seen in IDLE or HOLD is a protocol error: ignore it and raise a simulation assertion.

Decomposition:
- Package fp_pkg: OP_FADD = 1'b0, OP_FSUB = 1'b1, CANON_NAN = 32'h7FC00000, POS_INF = 32'h7F800000, NEG_INF = 32'hFF800000, state encodings.
- Sub-module fp_class (combinational), one instance per operand: outputs is_nan, is_snan, is_inf, is_zero, is_sub. It is reused later by fcmp/fclass.

Test Plan:
- FADD 0x3F800000 + 0x40000000, wb_ready = 1 -> fa_valid pulses once, wb_data = 0x40400000, nv = of = 0, wb_lat equals the measured fadd cycles.
- FSUB 0x3F800000 - 0x3F800000 -> fa_b = 0xBF800000, wb_data = 0x00000000.
- FADD 0x7F800000 + 0xFF800000 -> 0x7FC00000, nv = 1. FADD 0x7F800001 + 0x3F800000 -> 0x7FC00000, nv = 1. FADD 0x7FC00001 + 0x3F800000 -> nv = 0.
- FADD 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, of = 1. FADD 0x7F800000 + 0x3F800000 -> of = 0.
- wb_ready held 0 for 5 cycles in HOLD -> wb_valid and wb_* stable, req_ready = 0; the result is accepted on the 6th cycle.
- flush during WAIT, then FADD 0x40400000 + 0x3F800000 -> no wb_valid for the flushed op; the next op gives wb_data = 0x40800000 with the correct rd. Also reset asserted in WAIT -> IDLE next cycle, wb_valid = 0.
